// File: rtl/regs_pkg.sv
// Shared register-file widths and constants so decode, execute and writeback agree.
package regs_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int REG_NUM_DEF = 32;
    localparam int REG_AW_DEF  = 5;
    localparam int CNT_W_DEF   = 32;

    localparam logic [XLEN_DEF-1:0]   ZERO_WORD = 32'h0;
    localparam logic [REG_AW_DEF-1:0] REG_ZERO  = 5'd0;

endpackage

// File: rtl/regs_rd_port.sv
// One combinational read port: x0 forces zero, a same-cycle writeback to the
// addressed register is forwarded, otherwise the stored value is returned.
module regs_rd_port
    import regs_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] raddr,
    input  logic [XLEN-1:0]   stored,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wbaddr,
    input  logic [XLEN-1:0]   wbdata,
    output logic [XLEN-1:0]   rdata
);

    always_comb begin
        rdata = stored;
        if (raddr == '0) begin
            rdata = '0;
        end else if (wb_en && (wbaddr == raddr)) begin
            rdata = wbdata;
        end
    end

endmodule

// File: rtl/regs.sv
// Architectural integer register file with same-cycle write bypass on all
// three read ports and a wrapping count of committed writes.
module regs
    import regs_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int REG_NUM = REG_NUM_DEF,
    parameter int REG_AW  = REG_AW_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_en_i,
    input  logic [REG_AW-1:0] wbaddr_i,
    input  logic [XLEN-1:0]   wbdata_i,
    input  logic [REG_AW-1:0] raddr1_i,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [XLEN-1:0]   rdata1_o,
    output logic [XLEN-1:0]   rdata2_o,
    input  logic [REG_AW-1:0] dbg_addr_i,
    output logic [XLEN-1:0]   dbg_data_o,
    output logic [CNT_W-1:0]  wr_count_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [XLEN-1:0]  mem [REG_NUM];
    logic [CNT_W-1:0] wr_count;
    logic             commit;
    logic             byp_en;

    assign commit = wb_en_i && (wbaddr_i != '0);

    // Storage is all-zero during reset, so masking the bypass makes every port read 0.
    assign byp_en = wb_en_i && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_NUM; i++) begin
                mem[i] <= '0;
            end
        end else if (commit) begin
            mem[wbaddr_i] <= wbdata_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count <= '0;
        end else if (commit) begin
            wr_count <= wr_count + CNT_ONE;
        end
    end

    assign wr_count_o = wr_count;

    regs_rd_port #(.XLEN(XLEN), .REG_AW(REG_AW)) u_rd1 (
        .raddr  (raddr1_i),
        .stored (mem[raddr1_i]),
        .wb_en  (byp_en),
        .wbaddr (wbaddr_i),
        .wbdata (wbdata_i),
        .rdata  (rdata1_o)
    );

    regs_rd_port #(.XLEN(XLEN), .REG_AW(REG_AW)) u_rd2 (
        .raddr  (raddr2_i),
        .stored (mem[raddr2_i]),
        .wb_en  (byp_en),
        .wbaddr (wbaddr_i),
        .wbdata (wbdata_i),
        .rdata  (rdata2_o)
    );

    regs_rd_port #(.XLEN(XLEN), .REG_AW(REG_AW)) u_rd_dbg (
        .raddr  (dbg_addr_i),
        .stored (mem[dbg_addr_i]),
        .wb_en  (byp_en),
        .wbaddr (wbaddr_i),
        .wbdata (wbdata_i),
        .rdata  (dbg_data_o)
    );

endmodule

// File: tb/tb_regs.sv
// Randomized and directed bench for regs against a behavioural register-file model;
// a second instance with a 4-bit counter exercises the wrap.
module tb_regs;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_en = 1'b0;
    logic [4:0]  wbaddr = '0;
    logic [31:0] wbdata = '0;
    logic [4:0]  raddr1 = '0;
    logic [4:0]  raddr2 = '0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] rdata1, rdata2, dbg_data, wr_count;
    logic [31:0] rdata1_n, rdata2_n, dbg_data_n;
    logic [3:0]  wr_count4;

    int checks = 0;
    int errors = 0;

    logic [31:0] mref [32];
    int unsigned cnt;

    always #5 clk = ~clk;

    regs dut (
        .clk        (clk),
        .reset      (reset),
        .wb_en_i    (wb_en),
        .wbaddr_i   (wbaddr),
        .wbdata_i   (wbdata),
        .raddr1_i   (raddr1),
        .raddr2_i   (raddr2),
        .rdata1_o   (rdata1),
        .rdata2_o   (rdata2),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data),
        .wr_count_o (wr_count)
    );

    regs #(.CNT_W(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .wb_en_i    (wb_en),
        .wbaddr_i   (wbaddr),
        .wbdata_i   (wbdata),
        .raddr1_i   (raddr1),
        .raddr2_i   (raddr2),
        .rdata1_o   (rdata1_n),
        .rdata2_o   (rdata2_n),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data_n),
        .wr_count_o (wr_count4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_en && wbaddr == a) return wbdata;
        return mref[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mref[i] = 32'h0;
        cnt = 0;
    endtask

    // Check the combinational outputs, then clock once and update the model.
    task automatic step();
        #1;
        chk("rd1", rdata1, exp_rd(raddr1));
        chk("rd2", rdata2, exp_rd(raddr2));
        chk("dbg", dbg_data, exp_rd(dbg_addr));
        chk("rd1_n", rdata1_n, exp_rd(raddr1));
        chk("cnt", wr_count, cnt);
        chk("cnt4", {28'h0, wr_count4}, cnt % 16);
        @(posedge clk);
        if (wb_en && wbaddr != 0) begin
            mref[wbaddr] = wbdata;
            cnt++;
        end
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wbaddr = a; wbdata = d;
        step();
        wb_en = 1'b0;
    endtask

    // Reset pulse entirely between two rising edges.
    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        chk("rst_rd1", rdata1, 32'h0);
        chk("rst_rd2", rdata2, 32'h0);
        chk("rst_dbg", dbg_data, 32'h0);
        chk("rst_cnt", wr_count, 32'h0);
        chk("rst_cnt4", {28'h0, wr_count4}, 32'h0);
        model_clear();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        model_clear();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        // During reset every port reads zero, even with a bypass candidate driven.
        for (int i = 1; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(i); dbg_addr = 5'(i);
            wb_en = i[0]; wbaddr = 5'(i); wbdata = 32'hCAFE0000 | i;
            #1;
            chk("rstloop_rd1", rdata1, 32'h0);
            chk("rstloop_rd2", rdata2, 32'h0);
            chk("rstloop_dbg", dbg_data, 32'h0);
            chk("rstloop_cnt", wr_count, 32'h0);
        end
        wb_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            raddr1 = 5'($urandom_range(31)); raddr2 = 5'($urandom_range(31));
            dbg_addr = 5'($urandom_range(31));
            step();
        end

        // Basic write then read.
        raddr1 = 5; raddr2 = 5;
        wr(5, 32'hDEADBEEF);
        #1;
        chk("basic_rd1", rdata1, 32'hDEADBEEF);
        chk("basic_rd2", rdata2, 32'hDEADBEEF);
        chk("basic_cnt", wr_count, 32'd1);
        step();

        // x0 writes are discarded, no bypass, no count.
        wb_en = 1'b1; wbaddr = 0; wbdata = 32'hFFFFFFFF; raddr1 = 0;
        #1;
        chk("x0_same", rdata1, 32'h0);
        step();
        wb_en = 1'b0;
        #1;
        chk("x0_next", rdata1, 32'h0);
        chk("x0_cnt", wr_count, 32'd1);
        step();

        // Same-cycle bypass on rs1 only.
        wr(7, 32'h1);
        wr(8, 32'h33);
        wb_en = 1'b1; wbaddr = 7; wbdata = 32'h2; raddr1 = 7; raddr2 = 8;
        #1;
        chk("byp_rd1", rdata1, 32'h2);
        chk("byp_rd2", rdata2, 32'h33);
        step();
        wb_en = 1'b0;
        #1;
        chk("byp_after", rdata1, 32'h2);
        step();

        // Reset during a pending write: write lost, everything zero.
        wr(3, 32'hA5);
        wb_en = 1'b1; wbaddr = 3; wbdata = 32'h5A; dbg_addr = 3;
        pulse_reset();
        wb_en = 1'b0;
        #1;
        chk("mid_rst_dbg", dbg_data, 32'h0);
        chk("mid_rst_cnt", wr_count, 32'h0);
        step();
        wr(3, 32'h77);
        #1;
        chk("post_rst_wr", dbg_data, 32'h77);
        chk("post_rst_cnt", wr_count, 32'd1);
        step();

        // Counter wrap on the 4-bit instance, x0 writes interleaved.
        pulse_reset();
        for (int i = 0; i < 15; i++) begin
            wr(1, 32'(i));
            if (i % 4 == 0) wr(0, 32'h12345678);
        end
        #1;
        chk("wrap_15", {28'h0, wr_count4}, 32'd15);
        step();
        wr(0, 32'hFFFF0000);
        #1;
        chk("wrap_x0", {28'h0, wr_count4}, 32'd15);
        step();
        wr(1, 32'h99);
        #1;
        chk("wrap_0", {28'h0, wr_count4}, 32'd0);
        chk("wrap_cnt32", wr_count, 32'd16);
        step();

        // Random traffic, idle cycles carry garbage address/data.
        for (int n = 0; n < 600; n++) begin
            wb_en = ($urandom_range(3) != 0);
            wbaddr = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
            wbdata = $urandom;
            raddr1 = ($urandom_range(2) == 0) ? wbaddr : 5'($urandom_range(31));
            raddr2 = ($urandom_range(2) == 0) ? raddr1 : 5'($urandom_range(31));
            dbg_addr = 5'($urandom_range(31));
            if ($urandom_range(59) == 0) pulse_reset();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/regs.md
Name: regs

Overview:
- Architectural integer register file at the receiving end of the writeback interface.
- Accepts wb_en/wbaddr/wbdata from the writeback stage and provides two combinational read ports to decode, plus one debug read port.
- Same-cycle write-to-read bypass, so decode sees a value being written back in the same cycle without an extra forwarding path.
- Keeps a wrapping count of committed register writes for performance and debug observation.

Parameters:
XLEN, 32, data width of each register
REG_NUM, 32, number of architectural registers (x0..x31)
REG_AW, 5, register address width (log2 REG_NUM)
CNT_W, 32, width of the committed-write counter

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
wb_en_i  input  1  writeback enable from writeback stage
wbaddr_i  input  REG_AW  destination register index
wbdata_i  input  XLEN  writeback data
raddr1_i  input  REG_AW  rs1 index from decode
raddr2_i  input  REG_AW  rs2 index from decode
rdata1_o  output  XLEN  rs1 value
rdata2_o  output  XLEN  rs2 value
dbg_addr_i  input  REG_AW  debug read index
dbg_data_o  output  XLEN  debug read value
wr_count_o  output  CNT_W  committed-write counter

Behaviour:
- Single clock domain, clk.
- Reset is asynchronous and active-high.
- While reset is asserted:
  - all REG_NUM registers are cleared to 0 immediately (no clock edge needed);
  - wr_count_o = 0;
  - rdata1_o, rdata2_o and dbg_data_o all read 0.
- Write: on a rising clk edge with reset low, wb_en_i=1 and wbaddr_i!=0, wbdata_i is stored into register wbaddr_i. Write latency is one edge.
- x0: a write with wbaddr_i=0 is discarded. Reads of index 0 always return 0 on every port, including the bypass path.
- Read ports are combinational and share one rule, evaluated per port:
  - raddr==0 -> 0;
  - else if wb_en_i=1 and wbaddr_i==raddr -> wbdata_i (bypass);
  - else -> stored value.
- Bypass applies to rs1, rs2 and debug alike.
- Both read ports may address the same register, or the register being written; each resolves independently by the rule above.
- wr_count_o:
  - increments by 1 on each edge where a write actually commits (wb_en_i=1, wbaddr_i!=0, reset low);
  - writes to x0 do not count;
  - wraps from 2^CNT_W-1 to 0 with no flag.
- Repeated writes to the same register on consecutive edges: the last write wins. Each one counts.
- Reset asserted in the middle of a cycle with wb_en_i=1: the pending write is lost, all registers are zero, and the counter is zero. The first write after release behaves normally.
- X handling: when wb_en_i=0, wbaddr_i and wbdata_i are don't-care and must not affect state or outputs.
- No handshake back to writeback; the register file is always ready. One write per cycle maximum.
- Out-of-range indices cannot occur because REG_NUM = 2^REG_AW.

Decomposition:
- Shared defines file, alongside the existing instruction-opcode macros:
  - ZERO_WORD (32'h0);
  - REG_ZERO (5'd0);
  - default REG_NUM and REG_AW values, so decode, execute and writeback agree on widths.
- Optional sub-module regs_rd_port: pure combinational bypass/zero mux, instantiated three times (rs1, rs2, debug). It takes raddr, stored value, wb_en, wbaddr and wbdata.
- Storage, write logic and counter stay in regs.

Test Plan:
- Reset then read: assert reset, read x1..x31 on all ports -> every read returns 0 and wr_count_o=0. Deassert, no writes -> values remain 0.
- Basic write/read: write x5=32'hDEADBEEF, then idle one cycle with raddr1=5, raddr2=5 -> both return 32'hDEADBEEF and wr_count_o=1.
- x0 protection: wb_en=1, wbaddr=0, wbdata=32'hFFFFFFFF, with raddr1=0 in the same and the next cycle -> rdata1=0 both times and wr_count_o unchanged.
- Same-cycle bypass: x7 holds 32'h1. Drive wb_en=1, wbaddr=7, wbdata=32'h2 with raddr1=7, raddr2=8 -> rdata1=32'h2 before the edge and rdata2 unchanged. After the edge, with wb_en=0, rdata1=32'h2.
- Async reset mid-write: x3=32'hA5 stored. Mid-cycle, wb_en=1, wbaddr=3, wbdata=32'h5A, then pulse reset between edges -> dbg_data_o for x3 is 0 immediately, and stays 0 after release with wb_en=0. wr_count_o=0.
- Counter wrap (CNT_W=4 build): 15 commits to x1 -> wr_count_o=15. The next commit -> 0. Interleaved x0 writes -> no increment.
